// File: rtl/frv_core_fetch_req_if.sv
// Instruction memory request/response channel between the fetch request
// generator (master) and the instruction memory system (slave).
interface frv_core_fetch_req_if;
  logic        imem_req;
  logic        imem_gnt;
  logic [31:0] imem_addr;
  logic        imem_recv;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_error;

  modport master (
    output imem_req,
    input  imem_gnt,
    output imem_addr,
    input  imem_recv,
    output imem_ack,
    input  imem_rdata,
    input  imem_error
  );

  modport slave (
    input  imem_req,
    output imem_gnt,
    input  imem_addr,
    output imem_recv,
    input  imem_ack,
    output imem_rdata,
    output imem_error
  );
endinterface

// File: rtl/frv_core_fetch_req.sv
// Instruction fetch request generator and response steering stage.
// Issues word-aligned reads, tracks outstanding reads, forwards responses to
// the fetch buffer as 4-byte or 2-byte loads, and drops responses belonging
// to a stream abandoned by a control-flow redirect.
// Optional build macro: FRV_FETCH_DISCARD_CNT_EN adds dbg_discards, a
// saturating count of dropped responses.
module frv_core_fetch_req #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_ADDR      = 32'h8000_0000
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic                 cf_req,
  input  logic [31:0]          cf_target,
  output logic                 cf_ack,
  frv_core_fetch_req_if.master imem,
  output logic                 flush,
  output logic                 f_4byte,
  output logic                 f_2byte,
  output logic                 f_err,
  output logic [31:0]          f_in,
  input  logic                 f_ready
`ifdef FRV_FETCH_DISCARD_CNT_EN
  ,
  output logic [7:0]           dbg_discards
`endif
);

  localparam logic [2:0]  MAX_OUT    = 3'(MAX_OUTSTANDING);
  localparam logic [31:0] RESET_WORD = {RESET_ADDR[31:2], 2'b00};

  typedef enum logic [0:0] {RUN, ERR} state_t;

  state_t      state;
  logic        active;      // low until the first edge after reset release
  logic [1:0]  out_cnt;     // issued-but-unresponded reads
  logic [1:0]  disc_cnt;    // responses still owed to an abandoned stream
  logic        half_first;  // next forwarded word starts at its upper halfword

  logic        grant;
  logic        resp;
  logic        drop;
  logic        fwd_vld;
  logic        fwd_hs;
  logic        err_hs;
  logic [1:0]  out_nxt;
  logic [2:0]  disc_nxt;
  state_t      state_nxt;
  logic        unused_bits;

  // Redirect target bit 0 carries no information for halfword-aligned targets.
  assign unused_bits = cf_target[0];

  // Handshake decode, response steering and next-count arithmetic.
  always_comb begin
    grant         = imem.imem_req && imem.imem_gnt;
    // A pending ungranted request must complete before a redirect is taken.
    cf_ack        = active && cf_req && !(imem.imem_req && !imem.imem_gnt);
    flush         = cf_ack;
    // Responses owed to the old stream, or arriving with a redirect, are dropped.
    drop          = (disc_cnt != 2'd0) || cf_ack;
    imem.imem_ack = active && (drop || f_ready);
    resp          = imem.imem_recv && imem.imem_ack;
    fwd_vld       = active && !drop && imem.imem_recv;
    fwd_hs        = fwd_vld && f_ready;
    err_hs        = fwd_hs && imem.imem_error;
    f_in          = fwd_vld ? imem.imem_rdata : 32'h0;
    f_err         = fwd_vld && imem.imem_error;
    f_2byte       = fwd_hs && half_first;
    f_4byte       = fwd_hs && !half_first;
    out_nxt       = out_cnt + {1'b0, grant} - {1'b0, resp};
    disc_nxt      = {1'b0, out_cnt} + {2'b00, grant} - {2'b00, resp};
    state_nxt     = state;
    if (cf_ack) begin
      state_nxt = RUN;
    end else if (err_hs) begin
      state_nxt = ERR;
    end
  end

  // Fetch FSM: request issue, address sequencing and stream bookkeeping.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state          <= RUN;
      active         <= 1'b0;
      out_cnt        <= 2'd0;
      disc_cnt       <= 2'd0;
      half_first     <= 1'b0;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= RESET_WORD;
    end else begin
      active  <= 1'b1;
      state   <= state_nxt;
      out_cnt <= out_nxt;

      if (imem.imem_req && !imem.imem_gnt) begin
        imem.imem_req <= 1'b1;
      end else begin
        imem.imem_req <= (state_nxt == RUN) && ({1'b0, out_nxt} < MAX_OUT);
      end

      if (cf_ack) begin
        imem.imem_addr <= {cf_target[31:2], 2'b00};
        half_first     <= cf_target[1];
        disc_cnt       <= disc_nxt[1:0];
      end else begin
        if (grant) begin
          imem.imem_addr <= imem.imem_addr + 32'd4;
        end
        if (fwd_hs) begin
          half_first <= 1'b0;
        end
        if (disc_cnt != 2'd0 && imem.imem_recv) begin
          disc_cnt <= disc_cnt - 2'd1;
        end
      end
    end
  end

`ifdef FRV_FETCH_DISCARD_CNT_EN
  // Saturating count of responses dropped on behalf of abandoned streams.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      dbg_discards <= 8'h00;
    end else if (active && imem.imem_recv && drop && dbg_discards != 8'hFF) begin
      dbg_discards <= dbg_discards + 8'h01;
    end
  end
`endif

endmodule

// File: doc/frv_core_fetch_req.md
Name: frv_core_fetch_req

Overview:
Instruction fetch request generator and response steering stage, sitting directly upstream of the core fetch buffer.
- Issues word-aligned 32-bit reads on the instruction memory request channel.
- Tracks outstanding transactions.
- Forwards responses into the fetch buffer as 4-byte or 2-byte loads.
- On a control-flow change, flushes the fetch buffer and discards stale in-flight responses.

Parameters:
MAX_OUTSTANDING, 2, maximum issued-but-unresponded reads (1..3); outstanding counter is 2 bits.
RESET_ADDR, 32'h8000_0000, first fetch address after reset; bits [1:0] ignored.

Ports:
g_clk  input  1  global clock
g_resetn  input  1  asynchronous active-low reset
cf_req  input  1  control-flow change (redirect) request
cf_target  input  32  redirect target address, halfword aligned
cf_ack  output  1  redirect accepted this cycle
imem_req  output  1  memory read request valid
imem_gnt  input  1  memory accepts request
imem_addr  output  32  read address, bits [1:0] always 0
imem_recv  input  1  response valid
imem_ack  output  1  response consumed
imem_rdata  input  32  response data
imem_error  input  1  response bus error
flush  output  1  clear fetch buffer
f_4byte  output  1  load whole word into buffer
f_2byte  output  1  load upper halfword only
f_err  output  1  forwarded error
f_in  output  32  forwarded data
f_ready  input  1  buffer can accept data

Behaviour:
- Reset values: imem_req=0, imem_addr=RESET_ADDR&~3, cf_ack=0, flush=0, f_4byte=0, f_2byte=0, f_err=0, f_in=0, imem_ack=0.
- Internal state: outstanding counter, discard counter, half_first flag; all reset to 0. State reset value is RUN.
- States:
  - RUN: issuing requests.
  - ERR: entered on forwarding an error response. No new requests are issued. Exit only via an accepted cf_req.
- Issue rule:
  - imem_req=1 in RUN when outstanding < MAX_OUTSTANDING.
  - Once asserted, imem_req and imem_addr hold stable until imem_gnt.
  - On imem_req&&imem_gnt, imem_addr += 4. Wraps 32'hFFFF_FFFC -> 0.
  - First request appears the cycle after reset release.
- Outstanding counter: +1 on grant, -1 on response handshake (imem_recv&&imem_ack); both in the same cycle leaves it unchanged.
- Response steering:
  - When the discard counter is non-zero: imem_ack=1, response dropped, discard counter -1, f_* stay 0.
  - Otherwise: imem_ack=f_ready, and the response is forwarded combinationally.
    - f_in=imem_rdata, f_err=imem_error.
    - f_2byte=imem_recv&&f_ready&&half_first.
    - f_4byte=imem_recv&&f_ready&&!half_first.
    - half_first clears on the forward handshake.
- Redirect:
  - cf_ack=cf_req unless imem_req&&!imem_gnt (a pending request is never abandoned).
  - On cf_ack:
    - flush=1 the same cycle (combinational).
    - imem_addr<=cf_target&~3, half_first<=cf_target[1], state<=RUN.
    - discard counter <= outstanding + grant_this_cycle - response_this_cycle.
  - A response arriving in the cf_ack cycle belongs to the old stream. It is acked and dropped, f_* forced 0.
- Error: the forwarded response with imem_error=1 moves state to ERR at the next edge. Outstanding responses still drain and forward normally.
- Reset mid-operation asynchronously returns everything to reset values. Responses to pre-reset requests are the memory system's responsibility.

Optional Feature:
FRV_FETCH_DISCARD_CNT_EN
- Defined: adds output dbg_discards (8 bits), a saturating count of dropped responses. It resets to 0, increments per dropped response and holds at 8'hFF.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset release, imem_gnt=1, responses after 1 cycle, f_ready=1 -> imem_addr sequence 8000_0000, 8000_0004, 8000_0008; each response gives f_4byte=1 with f_in=imem_rdata.
- imem_gnt=0 for 5 cycles, MAX_OUTSTANDING=2, no responses -> at most 2 grants total; imem_req held with a stable address while ungranted.
- 2 outstanding, cf_req target 0000_1002 -> cf_ack=1, flush=1; next imem_addr=0000_1000; 2 old responses dropped with no f_*; first new response gives f_2byte=1, then f_4byte.
- f_ready=0 while imem_recv=1 -> imem_ack=0, f_4byte=0, outstanding unchanged; f_ready=1 next cycle -> forwarded.
- Response with imem_error=1 -> f_err=1, f_4byte=1, imem_req then 0 indefinitely; cf_req to 0000_2000 restarts fetch there.
- cf_req while imem_req=1, imem_gnt=0 -> cf_ack=0 until the grant cycle; the redirected request is issued afterwards; the discard counter includes the granted request.
